axi_aw_w_sync: RTL and testbench

// - Write-path ordering stage downstream of two axi_single_slice buffers (AW and W).
// - Forwards AW requests and releases W beats only for bursts whose AW has already been accepted.
// - Regenerates WLAST from AWLEN, flags upstream WLAST mismatches, and bounds outstanding AW-without-W bursts.

---
 rtl/axi_slice_pkg.sv | 18 +
 rtl/axi_aw_w_sync_fifo.sv | 104 ++++++++++
 rtl/axi_aw_w_sync.sv | 128 ++++++++++++
 tb/tb_axi_aw_w_sync.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slice_pkg.sv
// -----------------------------------------------------------------------------
// axi_slice_pkg
// Shared types and helpers for the AXI slice / write-path ordering blocks.
//   len_t      : AXI AxLEN value (burst length minus one)
//   cnt_width  : bits needed to hold a counter ranging 0..n inclusive
// -----------------------------------------------------------------------------
package axi_slice_pkg;

  localparam int unsigned LEN_WIDTH = 8;

  typedef logic [LEN_WIDTH-1:0] len_t;

  // Width of a counter that must represent every value from 0 up to n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axi_aw_w_sync_fifo.sv
// -----------------------------------------------------------------------------
// axi_aw_w_sync_fifo
// Small synchronous FIFO used as the AWLEN queue of axi_aw_w_sync.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                synchronous clear of the contents
//   testmode_i             reserved, no effect
//   full_o, empty_o        status
//   usage_o                number of stored entries
//   data_i, push_i         write side (ignored while full)
//   data_o, pop_i          read side (ignored while empty)
// -----------------------------------------------------------------------------
module axi_aw_w_sync_fifo #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_W:0]       usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic                  do_push_s, do_pop_s;
  logic                  unused_testmode_s;

  assign unused_testmode_s = testmode_i;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == '0);
  assign usage_o   = cnt_q;
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  if (FALL_THROUGH) begin : g_ft
    assign data_o = empty_o ? data_i : mem_q[rd_ptr_q];
  end else begin : g_reg
    assign data_o = mem_q[rd_ptr_q];
  end

  // Next pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_d = cnt_q + (ADDR_W + 1)'(1);
        2'b01:   cnt_d = cnt_q - (ADDR_W + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/axi_aw_w_sync.sv
// -----------------------------------------------------------------------------
// axi_aw_w_sync
// Write-path ordering stage: forwards AW requests and only lets W beats through
// for bursts whose AW has been accepted. WLAST is regenerated from AWLEN; the
// upstream WLAST is only compared and a mismatch raises last_err_o for a cycle.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   aw_valid_i/aw_ready_o/aw_*_i    AW from upstream slice
//   aw_valid_o/aw_ready_i/aw_*_o    AW to downstream
//   w_valid_i/w_ready_o/w_*_i       W from upstream slice (w_last_i checked only)
//   w_valid_o/w_ready_i/w_*_o       W to downstream (w_last_o regenerated)
//   outstanding_o                   accepted bursts whose W is not complete
//   last_err_o                      one-cycle pulse on upstream WLAST mismatch
// -----------------------------------------------------------------------------
module axi_aw_w_sync
  import axi_slice_pkg::*;
#(
  parameter int unsigned AW_WIDTH        = 32,
  parameter int unsigned W_WIDTH         = 64,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [AW_WIDTH-1:0]  aw_data_i,
  input  logic [LEN_WIDTH-1:0] aw_len_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AW_WIDTH-1:0]  aw_data_o,
  output logic [LEN_WIDTH-1:0] aw_len_o,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic [W_WIDTH-1:0]   w_data_i,
  input  logic                 w_last_i,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [W_WIDTH-1:0]   w_data_o,
  output logic                 w_last_o,
  output logic [CNT_W-1:0]     outstanding_o,
  output logic                 last_err_o
);

  localparam int unsigned QADDR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                 full_s, empty_s;
  logic [LEN_WIDTH-1:0] head_len_s;
  logic [QADDR_W:0]     fifo_usage_unused_s;
  logic                 aw_hs_s, w_hs_s, beat_last_s, pop_s;

  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic                 last_err_q, last_err_d;

  // AW side: gated only by queue occupancy, never by anything on W.
  assign aw_valid_o = aw_valid_i & ~full_s;
  assign aw_ready_o = aw_ready_i & ~full_s;
  assign aw_data_o  = aw_data_i;
  assign aw_len_o   = aw_len_i;
  assign aw_hs_s    = aw_valid_o & aw_ready_i;

  // W side: released only once the burst's length sits at the queue head.
  assign beat_last_s = (beat_cnt_q == head_len_s);
  assign w_valid_o   = w_valid_i & ~empty_s;
  assign w_ready_o   = w_ready_i & ~empty_s;
  assign w_data_o    = w_data_i;
  assign w_last_o    = beat_last_s & ~empty_s;
  assign w_hs_s      = w_valid_i & w_ready_i & ~empty_s;
  assign pop_s       = w_hs_s & beat_last_s;

  assign outstanding_o = outstanding_q;
  assign last_err_o    = last_err_q;

  axi_aw_w_sync_fifo #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (LEN_WIDTH),
    .DEPTH        (MAX_OUTSTANDING),
    .ADDR_W       (QADDR_W)
  ) u_len_q (
    .clk_i      (clk_i),
    .rst_ni     (~rst_i),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (full_s),
    .empty_o    (empty_s),
    .usage_o    (fifo_usage_unused_s),
    .data_i     (aw_len_i),
    .push_i     (aw_hs_s),
    .data_o     (head_len_s),
    .pop_i      (pop_s)
  );

  // Beat counter, outstanding count and WLAST check.
  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    outstanding_d = outstanding_q;
    last_err_d    = 1'b0;
    if (w_hs_s) begin
      beat_cnt_d = beat_last_s ? '0 : beat_cnt_q + LEN_WIDTH'(1);
      last_err_d = (w_last_i != w_last_o);
    end else begin
      beat_cnt_d = beat_cnt_q;
      last_err_d = 1'b0;
    end
    // A push and a final-beat pop in the same cycle cancel out.
    case ({aw_hs_s, pop_s})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_q    <= '0;
      outstanding_q <= '0;
      last_err_q    <= 1'b0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      outstanding_q <= outstanding_d;
      last_err_q    <= last_err_d;
    end
  end

endmodule

// File: tb/tb_axi_aw_w_sync.sv
// -----------------------------------------------------------------------------
// tb_axi_aw_w_sync
// Directed and randomised-backpressure bench for axi_aw_w_sync. Inputs are
// driven just after the falling edge and outputs are sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_axi_aw_w_sync;

  localparam int AW_WIDTH = 32;
  localparam int W_WIDTH  = 64;
  localparam int LEN_W    = 8;
  localparam int MAX_OUT  = 4;
  localparam int NBURST   = 200;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic [AW_WIDTH-1:0] aw_data_i, aw_data_o;
  logic [LEN_W-1:0]    aw_len_i, aw_len_o;
  logic                w_valid_i, w_ready_o, w_last_i, w_valid_o, w_ready_i, w_last_o;
  logic [W_WIDTH-1:0]  w_data_i, w_data_o;
  logic [2:0]          outstanding_o;
  logic                last_err_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk_i = ~clk_i;

  axi_aw_w_sync #(
    .AW_WIDTH        (AW_WIDTH),
    .W_WIDTH         (W_WIDTH),
    .LEN_WIDTH       (LEN_W),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .aw_valid_i    (aw_valid_i),
    .aw_ready_o    (aw_ready_o),
    .aw_data_i     (aw_data_i),
    .aw_len_i      (aw_len_i),
    .aw_valid_o    (aw_valid_o),
    .aw_ready_i    (aw_ready_i),
    .aw_data_o     (aw_data_o),
    .aw_len_o      (aw_len_o),
    .w_valid_i     (w_valid_i),
    .w_ready_o     (w_ready_o),
    .w_data_i      (w_data_i),
    .w_last_i      (w_last_i),
    .w_valid_o     (w_valid_o),
    .w_ready_i     (w_ready_i),
    .w_data_o      (w_data_o),
    .w_last_o      (w_last_o),
    .outstanding_o (outstanding_o),
    .last_err_o    (last_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle, ending just after the next falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    aw_valid_i = 1'b0; aw_ready_i = 1'b0; aw_data_i = '0; aw_len_i = '0;
    w_valid_i  = 1'b0; w_ready_i  = 1'b0; w_data_i  = '0; w_last_i = 1'b0;
  endtask

  int lens [NBURST];
  int exp_beats, beats, aw_idx, wb, wbeat, cyc, data_bad, last_bad, err_cnt;
  logic [63:0] exp_data;
  logic exp_last;

  initial begin
    idle();
    rst_i = 1'b1;
    aw_valid_i = 1'b1;
    #12;
    // ---------------- reset state ----------------
    chk("rst_aw_valid", aw_valid_o, 1'b1);
    chk("rst_w_valid", w_valid_o, 1'b0);
    chk("rst_w_ready", w_ready_o, 1'b0);
    chk("rst_outst", outstanding_o, 3'd0);
    chk("rst_lerr", last_err_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle();
    step();

    // ---------------- len=3, W offered from the AW cycle ----------------
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_len_i = 8'd3; aw_data_i = 32'hCAFE_0001;
    w_valid_i = 1'b1; w_ready_i = 1'b1; w_data_i = 64'h100; w_last_i = 1'b0;
    #1;
    chk("t1_aw_ready", aw_ready_o, 1'b1);
    chk("t1_aw_data", aw_data_o, 64'hCAFE_0001);
    chk("t1_aw_len", aw_len_o, 8'd3);
    chk("t1_no_w_c0", w_valid_o, 1'b0);
    step();
    aw_valid_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w_data_i = 64'h100 + 64'(i);
      w_last_i = (i == 4);
      #1;
      chk("t1_w_valid", w_valid_o, 1'b1);
      chk("t1_w_last", w_last_o, (i == 4));
      chk("t1_w_data", w_data_o, 64'h100 + 64'(i));
      step();
    end
    #1;
    chk("t1_outst_end", outstanding_o, 3'd0);
    chk("t1_w_off", w_valid_o, 1'b0);
    chk("t1_no_err", last_err_o, 1'b0);
    idle();
    step();

    // ---------------- fill to MAX_OUTSTANDING ----------------
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_len_i = 8'd0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_aw_ready", aw_ready_o, (k < 4));
      step();
    end
    #1;
    chk("t2_outst_full", outstanding_o, 3'd4);
    chk("t2_aw_valid_full", aw_valid_o, 1'b0);
    w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = 1'b1;
    #1;
    chk("t2_aw_blk_pop", aw_ready_o, 1'b0);
    chk("t2_w_last", w_last_o, 1'b1);
    step();
    w_valid_i = 1'b0;
    #1;
    chk("t2_outst_3", outstanding_o, 3'd3);
    chk("t2_aw_ready_again", aw_ready_o, 1'b1);
    step();
    aw_valid_i = 1'b0;
    #1;
    chk("t2_outst_4", outstanding_o, 3'd4);
    w_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) step();
    #1;
    chk("t2_drained", outstanding_o, 3'd0);
    idle();
    step();

    // ---------------- upstream WLAST too early ----------------
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_len_i = 8'd1;
    step();
    aw_valid_i = 1'b0;
    w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = 1'b1;
    #1;
    chk("t3_b0_last", w_last_o, 1'b0);
    chk("t3_b0_noerr", last_err_o, 1'b0);
    step();
    #1;
    chk("t3_err_pulse", last_err_o, 1'b1);
    chk("t3_b1_last", w_last_o, 1'b1);
    step();
    #1;
    chk("t3_err_clear", last_err_o, 1'b0);
    chk("t3_outst", outstanding_o, 3'd0);
    idle();
    step();

    // ---------------- final-beat pop and push together at count 2 ----------------
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_len_i = 8'd0;
    step();
    aw_len_i = 8'd2;
    step();
    aw_len_i = 8'd1;
    w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = 1'b1;
    #1;
    chk("t4_outst_pre", outstanding_o, 3'd2);
    chk("t4_a_last", w_last_o, 1'b1);
    step();
    aw_valid_i = 1'b0;
    #1;
    chk("t4_outst_same", outstanding_o, 3'd2);
    for (int i = 0; i < 5; i++) begin
      exp_last = (i == 2) || (i == 4);
      w_last_i = exp_last;
      #1;
      chk("t4_seq_last", w_last_o, exp_last);
      step();
      #1;
      chk("t4_seq_outst", outstanding_o, (i < 2) ? 3'd2 : (i < 4) ? 3'd1 : 3'd0);
    end
    idle();
    step();

    // ---------------- reset mid-burst ----------------
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_len_i = 8'd7;
    step();
    aw_valid_i = 1'b0;
    w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = 1'b0;
    step();
    step();
    #2;
    chk("t5_pre_rst_wv", w_valid_o, 1'b1);
    rst_i = 1'b1;
    aw_valid_i = 1'b1;
    #1;
    chk("t5_rst_wv", w_valid_o, 1'b0);
    chk("t5_rst_wr", w_ready_o, 1'b0);
    chk("t5_rst_outst", outstanding_o, 3'd0);
    chk("t5_rst_awv", aw_valid_o, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle();
    step();
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_len_i = 8'd1;
    step();
    aw_valid_i = 1'b0;
    w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = 1'b0;
    #1;
    chk("t5_restart_b0", w_last_o, 1'b0);
    step();
    w_last_i = 1'b1;
    #1;
    chk("t5_restart_b1", w_last_o, 1'b1);
    step();
    #1;
    chk("t5_restart_err", last_err_o, 1'b0);
    idle();
    step();

    // ---------------- random backpressure, 200 bursts ----------------
    exp_beats = 0;
    for (int i = 0; i < NBURST; i++) begin
      lens[i] = int'($urandom_range(255, 0));
      exp_beats += lens[i] + 1;
    end
    beats = 0; aw_idx = 0; wb = 0; wbeat = 0; cyc = 0;
    data_bad = 0; last_bad = 0; err_cnt = 0;
    while (wb < NBURST && cyc < 80000) begin
      aw_valid_i = (aw_idx < NBURST) && ($urandom_range(3, 0) != 0);
      aw_len_i   = LEN_W'(lens[(aw_idx < NBURST) ? aw_idx : 0]);
      aw_data_i  = 32'(aw_idx);
      aw_ready_i = ($urandom_range(3, 0) != 0);
      w_valid_i  = ($urandom_range(7, 0) != 0);
      exp_data   = {32'(wb), 32'(wbeat)};
      w_data_i   = exp_data;
      w_last_i   = (wbeat == lens[wb]);
      w_ready_i  = ($urandom_range(7, 0) != 0);
      #1;
      if (last_err_o) err_cnt++;
      if (aw_valid_o && aw_ready_i) aw_idx++;
      if (w_valid_o && w_ready_i) begin
        beats++;
        if (w_data_o !== exp_data) data_bad++;
        if (w_last_o !== (wbeat == lens[wb])) last_bad++;
        if (wbeat == lens[wb]) begin
          wb++;
          wbeat = 0;
        end else begin
          wbeat++;
        end
      end
      @(negedge clk_i);
      cyc++;
    end
    idle();
    #1;
    if (last_err_o) err_cnt++;
    chk("rnd_timeout", (cyc < 80000), 1'b1);
    chk("rnd_bursts", wb, NBURST);
    chk("rnd_beats", beats, exp_beats);
    chk("rnd_data_bad", data_bad, 0);
    chk("rnd_last_bad", last_bad, 0);
    chk("rnd_last_err", err_cnt, 0);
    chk("rnd_outst_end", outstanding_o, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
